// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/logic/shift) return one cycle after acceptance.
// Unsigned multiply/divide run on a shared iterative datapath, one step
// per cycle for WIDTH cycles. Result and flags stay registered until the
// consumer takes them.
module alu_mdu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);   // shift amount width
    localparam int CW = $clog2(WIDTH);   // step counter width (0..WIDTH-1)
    localparam logic [WIDTH-1:0] SH_MAX   = WIDTH'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             cy_q, cy_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    // Iterative unit: {hi,lo} is the product for MUL, {rem,quo} for DIV.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] bop_q, bop_d;
    logic [1:0]       mop_q, mop_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   addsub;
    logic [WIDTH-1:0] alu_y;
    logic             alu_ovf;
    logic             alu_cy;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic             res_we;
    logic [WIDTH-1:0] res_y;
    logic             res_ovf;
    logic             res_cy;

    assign accept    = in_valid && in_ready;
    assign in_ready  = rst_n && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && out_ready));
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_EXEC);
    assign y         = y_q;
    assign overflow  = ovf_q;
    assign carry     = cy_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

    // Single-cycle ALU on the live inputs; only consumed on an accept edge.
    always_comb begin
        shamt   = (b > SH_MAX) ? SW'(WIDTH - 1) : b[SW-1:0];
        addsub  = '0;
        alu_y   = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        case (op)
            4'b0000: begin
                addsub  = {1'b0, a} + {1'b0, b};
                alu_y   = addsub[WIDTH-1:0];
                alu_cy  = addsub[WIDTH];
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (addsub[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                // Bit WIDTH of the widened difference is the borrow.
                addsub  = {1'b0, a} - {1'b0, b};
                alu_y   = addsub[WIDTH-1:0];
                alu_cy  = addsub[WIDTH];
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (addsub[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: alu_y = a & b;
            4'b0011: alu_y = a | b;
            4'b0100: alu_y = a ^ b;
            4'b0101: alu_y = a << shamt;
            4'b0110: alu_y = a >> shamt;
            4'b0111: alu_y = $unsigned($signed(a) >>> shamt);
            default: alu_y = '0;   // reserved opcodes (MDU ops never use this)
        endcase
    end

    // One multiply or divide step from the current iterative state.
    always_comb begin
        // Shift-add: add b to the high half when the current low bit is set,
        // then shift the whole {carry,hi,lo} right by one.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bop_q} : '0);
        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor when it fits. With b == 0 every step
        // "fits", giving an all-ones quotient and a remainder equal to a.
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, bop_q});
        div_sub = div_sh - {1'b0, bop_q};
        if (mop_q[1]) begin
            step_hi = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Next-state: handshake FSM, iterative unit, and result capture.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        bop_d   = bop_q;
        mop_d   = mop_q;
        cnt_d   = cnt_q;
        res_we  = 1'b0;
        res_y   = '0;
        res_ovf = 1'b0;
        res_cy  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (op[3:2] == 2'b10) begin
                        state_d = S_EXEC;
                        hi_d    = '0;
                        lo_d    = a;
                        bop_d   = b;
                        mop_d   = op[1:0];
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        res_we  = 1'b1;
                        res_y   = alu_y;
                        res_ovf = alu_ovf;
                        res_cy  = alu_cy;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    res_we  = 1'b1;
                    case (mop_q)
                        2'b00: begin
                            res_y  = step_lo;
                            res_cy = (step_hi != '0);
                        end
                        2'b01: res_y = step_hi;
                        2'b10: begin
                            res_y   = step_lo;
                            res_ovf = (bop_q == '0);
                        end
                        default: begin
                            res_y   = step_hi;
                            res_ovf = (bop_q == '0);
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        y_d    = res_we ? res_y : y_q;
        ovf_d  = res_we ? res_ovf : ovf_q;
        cy_d   = res_we ? res_cy : cy_q;
        zero_d = res_we ? (res_y == '0) : zero_q;
        neg_d  = res_we ? res_y[WIDTH-1] : neg_q;
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            bop_q   <= '0;
            mop_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            cy_q    <= cy_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            bop_q   <= bop_d;
            mop_q   <= mop_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (WIDTH=8): vector table plus hand-written
// sequences for backpressure, back-to-back accept and reset mid-operation.
module tb_alu_mdu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         overflow;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         busy;

    alu_mdu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .overflow  (overflow),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         ovf;
        logic         cy;
        int           lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request with out_ready=1, time it, and check the result.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; they must have no effect.
        in_valid = 1'b0; a = ~v.a; b = ~v.b; op = 4'b0001;
        lat = 0; bcnt = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (out_valid) seen = 1'b1;
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " y"}, 32'(y), 32'(v.y));
        chk({nm, " overflow"}, 32'(overflow), 32'(v.ovf));
        chk({nm, " carry"}, 32'(carry), 32'(v.cy));
        chk({nm, " zero"}, 32'(zero), 32'(v.y == '0));
        chk({nm, " negative"}, 32'(negative), 32'(v.y[W-1]));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(v.lat - 1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            op     a      b      y      ovf   cy    lat
        vecs[0]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1};  // ADD signed ovf
        vecs[1]  = '{4'h1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1};  // SUB borrow
        vecs[2]  = '{4'h5, 8'h03, 8'h09, 8'h80, 1'b0, 1'b0, 1};  // SLL saturated to 7
        vecs[3]  = '{4'h6, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1};  // SRL
        vecs[4]  = '{4'h7, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1};  // SRA sign fill
        vecs[5]  = '{4'h7, 8'h80, 8'hC8, 8'hFF, 1'b0, 1'b0, 1};  // SRA saturated
        vecs[6]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};  // AND
        vecs[7]  = '{4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1};  // OR
        vecs[8]  = '{4'h4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1};  // XOR
        vecs[9]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1};  // ADD carry, zero
        vecs[10] = '{4'h1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1};  // SUB signed ovf
        vecs[11] = '{4'h8, 8'h10, 8'h20, 8'h00, 1'b0, 1'b1, 9};  // MUL high nonzero
        vecs[12] = '{4'h9, 8'h10, 8'h20, 8'h02, 1'b0, 1'b0, 9};  // MULHU
        vecs[13] = '{4'h8, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 9};  // MUL fits low half
        vecs[14] = '{4'h9, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9};  // MULHU max
        vecs[15] = '{4'hA, 8'd200, 8'd7, 8'h1C, 1'b0, 1'b0, 9};  // DIVU
        vecs[16] = '{4'hB, 8'd200, 8'd7, 8'h04, 1'b0, 1'b0, 9};  // REMU
        vecs[17] = '{4'hA, 8'h55, 8'h00, 8'hFF, 1'b1, 1'b0, 9};  // DIVU by zero
        vecs[18] = '{4'hB, 8'h55, 8'h00, 8'h55, 1'b1, 1'b0, 9};  // REMU by zero
        vecs[19] = '{4'hA, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9};  // DIVU a==b
        vecs[20] = '{4'hB, 8'h07, 8'h10, 8'h07, 1'b0, 1'b0, 9};  // REMU a<b
        vecs[21] = '{4'hC, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 1};  // reserved

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset flags", {28'd0, overflow, carry, zero, negative}, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: ADD result held for 5 cycles with out_ready low.
        @(negedge clk);
        op = 4'h0; a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp y", 32'(y), 32'h30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            #1;
            chk($sformatf("bp hold%0d y", i), 32'(y), 32'h30);
            chk($sformatf("bp hold%0d flags", i),
                {28'd0, overflow, carry, zero, negative}, 32'd0);
            chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
        end
        // Release with a new request pending: accepted on the same edge.
        op = 4'h4; a = 8'hF0; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b out_valid", 32'(out_valid), 32'd1);
        chk("b2b y", 32'(y), 32'hFF);
        chk("b2b negative", 32'(negative), 32'd1);
        @(posedge clk);
        #1;

        // Reset during the 4th cycle of a DIVU.
        @(negedge clk);
        op = 4'hA; a = 8'd200; b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst-mid busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst-mid out_valid", 32'(out_valid), 32'd0);
        chk("rst-mid busy", 32'(busy), 32'd0);
        chk("rst-mid y", 32'(y), 32'd0);
        chk("rst-mid in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst-mid release in_ready", 32'(in_ready), 32'd1);
        chk("rst-mid release out_valid", 32'(out_valid), 32'd0);
        chk("rst-mid release busy", 32'(busy), 32'd0);
        run_vec('{4'h0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1}, "post-rst ADD");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Registered, handshaked successor to the team's combinational ALU, generalised to any WIDTH.
- Keeps the 8 single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA.
- Adds iterative unsigned multiply and divide units: MUL, MULHU, DIVU, REMU.
- Sits between an issue stage and a writeback stage, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width in bits (>=4).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at clk edge
a  input  WIDTH  operand a
b  input  WIDTH  operand b / shift amount / divisor
op  input  4  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
overflow  output  1  signed overflow (ADD/SUB); divide-by-zero (DIVU/REMU)
carry  output  1  carry/borrow (ADD/SUB); high half nonzero (MUL)
zero  output  1  y == 0
negative  output  1  y[WIDTH-1]
busy  output  1  iterative operation in progress

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, busy=0, y=0, all flags 0; in_ready=0 while rst_n low.
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 MUL (low half), 1001 MULHU (high half), 1010 DIVU, 1011 REMU, 1100-1111 reserved.
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1.
  - Accept single-cycle or reserved op -> DONE; result registered that edge (latency 1).
  - Accept op[3:2]==2'b10 -> EXEC; operands latched, counter=0, busy=1.
- EXEC: in_ready=0. One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle for WIDTH cycles; after last step -> DONE, busy=0. Latency WIDTH+1 from acceptance to out_valid.
- DONE: out_valid=1. y/flags held stable while out_ready=0. in_ready = out_ready.
  - out_ready && in_valid: new request accepted the same edge (back-to-back).
  - out_ready && !in_valid -> IDLE, out_valid=0.
- ADD/SUB: computed at WIDTH+1 bits.
  - carry = bit WIDTH; for SUB this is borrow.
  - ADD overflow = same-sign inputs, result sign differs.
  - SUB overflow = differing-sign inputs, result sign differs from a.
- Logic ops: carry=0, overflow=0.
- Shifts: shift amount = b if b<WIDTH, else WIDTH-1 (saturating); SRA sign-fills; carry=0, overflow=0.
- MUL/MULHU: 2*WIDTH-bit unsigned product. MUL y=low half, carry=(high half!=0). MULHU y=high half, carry=0. overflow=0.
- DIVU/REMU: unsigned. If b==0: DIVU y=all ones, REMU y=a, overflow=1, still WIDTH+1 latency. Otherwise overflow=0. carry=0.
- Reserved op: y=0, zero=1, other flags 0, latency 1.
- zero and negative are always derived from the final y.
- Inputs a/b/op are ignored outside the accept edge; changes during EXEC have no effect.
- Reset mid-EXEC or mid-DONE: operation aborted and result discarded; after release the block is in IDLE.

Test Plan:
- ADD a=0x7F b=0x01, out_ready=1 -> out_valid 1 cycle after accept; y=0x80, overflow=1, carry=0, negative=1, zero=0.
- SUB a=0x00 b=0x01 -> y=0xFF, carry=1, overflow=0. SLL a=0x03 b=9 -> y=0x80 (saturated shift by 7).
- MUL a=0x10 b=0x20 -> out_valid exactly 9 cycles after accept; y=0x00, zero=1, carry=1; busy high 8 cycles. MULHU same operands -> y=0x02.
- DIVU a=200 b=7 -> y=0x1C; REMU -> y=0x04; DIVU a=0x55 b=0 -> y=0xFF, overflow=1; REMU a=0x55 b=0 -> y=0x55, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result -> y/flags stable, in_ready=0. Raise out_ready with in_valid=1 (XOR 0xF0^0x0F) -> accepted same edge; next result y=0xFF, negative=1.
- Assert rst_n=0 on cycle 4 of a DIVU -> out_valid=0, busy=0, y=0 immediately. After release in_ready=1; subsequent ADD 0x01+0x01 -> y=0x02.
